// File: rtl/traffic_sensor_conditioner_pkg.sv
// Shared light package slice for the traffic sensor conditioner.
// Provides the light colour type and the default tuning constants.
// Optional feature macro used by this block: SENSOR_STUCK_DET_EN.
package traffic_sensor_conditioner_pkg;

  typedef enum logic [1:0] {
    red    = 2'd0,
    yellow = 2'd1,
    green  = 2'd2
  } colors;

  localparam int DEB_CYC_DFLT    = 3;
  localparam int DEPART_CYC_DFLT = 2;
  localparam int QMAX_DFLT       = 15;
  localparam int STUCK_CYC_DFLT  = 64;
  localparam int CW_DFLT         = $clog2(QMAX_DFLT + 1);

endpackage

// File: rtl/traffic_sensor_conditioner_if.sv
// Sensor bus between the loop detectors / light controller and the conditioner.
// The slave side is the conditioner; the master side is the controller/environment.
interface traffic_sensor_conditioner_if
  import traffic_sensor_conditioner_pkg::*;
#(
  parameter int CW = CW_DFLT
);
  logic          ew_str_raw;
  logic          ew_left_raw;
  logic          ns_raw;
  colors         ew_str_light;
  colors         ew_left_light;
  colors         ns_light;
  logic          ew_str_sensor;
  logic          ew_left_sensor;
  logic          ns_sensor;
  logic [CW-1:0] ew_str_count;
  logic [CW-1:0] ew_left_count;
  logic [CW-1:0] ns_count;
  logic [2:0]    stuck;

  modport slave (
    input  ew_str_raw, ew_left_raw, ns_raw,
    input  ew_str_light, ew_left_light, ns_light,
    output ew_str_sensor, ew_left_sensor, ns_sensor,
    output ew_str_count, ew_left_count, ns_count,
    output stuck
  );

  modport master (
    output ew_str_raw, ew_left_raw, ns_raw,
    output ew_str_light, ew_left_light, ns_light,
    input  ew_str_sensor, ew_left_sensor, ns_sensor,
    input  ew_str_count, ew_left_count, ns_count,
    input  stuck
  );

endinterface

// File: rtl/traffic_sensor_conditioner_lane_sensor_filter.sv
// One lane of the sensor conditioner: debounce, arrival edge detect,
// vehicle queue with green-light departures, and (with SENSOR_STUCK_DET_EN)
// a sticky stuck-detector that forces the sensor high.
module lane_sensor_filter
  import traffic_sensor_conditioner_pkg::*;
#(
  parameter int DEB_CYC    = DEB_CYC_DFLT,
  parameter int DEPART_CYC = DEPART_CYC_DFLT,
`ifdef SENSOR_STUCK_DET_EN
  parameter int STUCK_CYC  = STUCK_CYC_DFLT,
`endif
  parameter int QMAX       = QMAX_DFLT,
  parameter int CW         = $clog2(QMAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          raw_i,
  input  colors         light_i,
  output logic          sensor_o,
  output logic [CW-1:0] count_o,
  output logic          stuck_o
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int TW = $clog2(DEPART_CYC + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [TW-1:0] DEP_LAST  = TW'(DEPART_CYC - 1);
  localparam logic [CW-1:0] QMAX_C    = CW'(QMAX);

  logic          deb_state_q, deb_state_d;
  logic          deb_prev_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [TW-1:0] dep_tmr_q, dep_tmr_d;
  logic [CW-1:0] q_q, q_d;
  logic          sensor_q, sensor_d;
  logic          stuck_d;
  logic          arrival_s;
  logic          depart_s;

  // Debounce, departure timer and queue next-state.
  always_comb begin
    deb_state_d = deb_state_q;
    deb_cnt_d   = '0;
    if (raw_i != deb_state_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_state_d = ~deb_state_q;
        deb_cnt_d   = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + {{(DW-1){1'b0}}, 1'b1};
      end
    end else begin
      deb_cnt_d = '0;
    end

    // Arrival is the rising edge of the debounced level, one edge after it rises.
    arrival_s = deb_state_q & ~deb_prev_q;

    depart_s  = 1'b0;
    dep_tmr_d = '0;
    if ((light_i == green) && (q_q != '0)) begin
      if (dep_tmr_q == DEP_LAST) begin
        depart_s  = 1'b1;
        dep_tmr_d = '0;
      end else begin
        dep_tmr_d = dep_tmr_q + {{(TW-1){1'b0}}, 1'b1};
      end
    end else begin
      dep_tmr_d = '0;
    end

    // Simultaneous arrival and departure cancel; arrivals at QMAX are dropped.
    q_d = q_q;
    if (arrival_s && !depart_s) begin
      if (q_q != QMAX_C) begin
        q_d = q_q + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        q_d = q_q;
      end
    end else if (depart_s && !arrival_s) begin
      q_d = q_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      q_d = q_q;
    end

    // Sensor is registered from q_d so it tracks q with no extra latency.
    sensor_d = (q_d != '0) | stuck_d;
  end

  // Main lane state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_state_q <= 1'b0;
      deb_prev_q  <= 1'b0;
      deb_cnt_q   <= '0;
      dep_tmr_q   <= '0;
      q_q         <= '0;
      sensor_q    <= 1'b0;
    end else begin
      deb_state_q <= deb_state_d;
      deb_prev_q  <= deb_state_q;
      deb_cnt_q   <= deb_cnt_d;
      dep_tmr_q   <= dep_tmr_d;
      q_q         <= q_d;
      sensor_q    <= sensor_d;
    end
  end

`ifdef SENSOR_STUCK_DET_EN
  localparam int SW = $clog2(STUCK_CYC + 1);
  localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYC - 1);

  logic [SW-1:0] stuck_cnt_q, stuck_cnt_d;
  logic          stuck_q;

  // Count consecutive raw-high cycles; the stuck flag is sticky until reset.
  always_comb begin
    stuck_cnt_d = '0;
    stuck_d     = stuck_q;
    if (raw_i) begin
      if (stuck_cnt_q == STUCK_LAST) begin
        stuck_d     = 1'b1;
        stuck_cnt_d = stuck_cnt_q;
      end else begin
        stuck_cnt_d = stuck_cnt_q + {{(SW-1){1'b0}}, 1'b1};
      end
    end else begin
      stuck_cnt_d = '0;
    end
  end

  // Stuck detector registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stuck_cnt_q <= '0;
      stuck_q     <= 1'b0;
    end else begin
      stuck_cnt_q <= stuck_cnt_d;
      stuck_q     <= stuck_d;
    end
  end

  assign stuck_o = stuck_q;
`else
  assign stuck_d = 1'b0;
  assign stuck_o = 1'b0;
`endif

  assign sensor_o = sensor_q;
  assign count_o  = q_q;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Traffic sensor conditioner top: three lane filters, each fed by its own
// raw detector and its own light. Stuck bits are packed {ns, ew_left, ew_str}.
// Optional feature macro: SENSOR_STUCK_DET_EN (stuck-detector fail-safe).
module traffic_sensor_conditioner
  import traffic_sensor_conditioner_pkg::*;
#(
  parameter int DEB_CYC    = DEB_CYC_DFLT,
  parameter int DEPART_CYC = DEPART_CYC_DFLT,
`ifdef SENSOR_STUCK_DET_EN
  parameter int STUCK_CYC  = STUCK_CYC_DFLT,
`endif
  parameter int QMAX       = QMAX_DFLT
) (
  input  logic                         clk,
  input  logic                         reset,
  traffic_sensor_conditioner_if.slave  bus_if
);

  localparam int CW = $clog2(QMAX + 1);

  logic [2:0] stuck_s;

  lane_sensor_filter #(
    .DEB_CYC    (DEB_CYC),
    .DEPART_CYC (DEPART_CYC),
`ifdef SENSOR_STUCK_DET_EN
    .STUCK_CYC  (STUCK_CYC),
`endif
    .QMAX       (QMAX),
    .CW         (CW)
  ) u_ew_str (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (bus_if.ew_str_raw),
    .light_i  (bus_if.ew_str_light),
    .sensor_o (bus_if.ew_str_sensor),
    .count_o  (bus_if.ew_str_count),
    .stuck_o  (stuck_s[0])
  );

  lane_sensor_filter #(
    .DEB_CYC    (DEB_CYC),
    .DEPART_CYC (DEPART_CYC),
`ifdef SENSOR_STUCK_DET_EN
    .STUCK_CYC  (STUCK_CYC),
`endif
    .QMAX       (QMAX),
    .CW         (CW)
  ) u_ew_left (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (bus_if.ew_left_raw),
    .light_i  (bus_if.ew_left_light),
    .sensor_o (bus_if.ew_left_sensor),
    .count_o  (bus_if.ew_left_count),
    .stuck_o  (stuck_s[1])
  );

  lane_sensor_filter #(
    .DEB_CYC    (DEB_CYC),
    .DEPART_CYC (DEPART_CYC),
`ifdef SENSOR_STUCK_DET_EN
    .STUCK_CYC  (STUCK_CYC),
`endif
    .QMAX       (QMAX),
    .CW         (CW)
  ) u_ns (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (bus_if.ns_raw),
    .light_i  (bus_if.ns_light),
    .sensor_o (bus_if.ns_sensor),
    .count_o  (bus_if.ns_count),
    .stuck_o  (stuck_s[2])
  );

  assign bus_if.stuck = stuck_s;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed self-checking bench for traffic_sensor_conditioner (default parameters).
module tb_traffic_sensor_conditioner;
  import traffic_sensor_conditioner_pkg::*;

`ifdef SENSOR_STUCK_DET_EN
  localparam bit STUCK_EN = 1'b1;
`else
  localparam bit STUCK_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  traffic_sensor_conditioner_if #(.CW(CW_DFLT)) bus ();

  traffic_sensor_conditioner dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_raw(input int lane, input logic v);
    case (lane)
      0: bus.ew_str_raw  = v;
      1: bus.ew_left_raw = v;
      default: bus.ns_raw = v;
    endcase
  endtask

  // Clean arrival: 3 high samples, then 3 low samples; queue bumps on the 4th edge.
  task automatic arrive(input int lane);
    set_raw(lane, 1'b1);
    step(3);
    set_raw(lane, 1'b0);
    step(3);
  endtask

  initial begin
    int exp_q;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.ew_str_raw    = 1'b0;
    bus.ew_left_raw   = 1'b0;
    bus.ns_raw        = 1'b0;
    bus.ew_str_light  = red;
    bus.ew_left_light = red;
    bus.ns_light      = red;
    step(2);
    check("rst_ew_str_count", 32'(bus.ew_str_count), 32'd0);
    check("rst_ns_count", 32'(bus.ns_count), 32'd0);
    check("rst_sensors", 32'({bus.ns_sensor, bus.ew_left_sensor, bus.ew_str_sensor}), 32'd0);
    check("rst_stuck", 32'(bus.stuck), 32'd0);
    reset = 1'b0;
    step(1);

    // 1. one-cycle glitches never reach the queue
    for (int i = 0; i < 4; i++) begin
      bus.ew_str_raw = (i % 2 == 0) ? 1'b1 : 1'b0;
      step(1);
    end
    step(4);
    check("glitch_count", 32'(bus.ew_str_count), 32'd0);
    check("glitch_sensor", 32'(bus.ew_str_sensor), 32'd0);

    // 2. ns arrival latency with red light
    bus.ns_raw = 1'b1;
    step(3);
    check("ns_lat_edge3", 32'(bus.ns_count), 32'd0);
    step(1);
    check("ns_lat_edge4_count", 32'(bus.ns_count), 32'd1);
    check("ns_lat_edge4_sensor", 32'(bus.ns_sensor), 32'd1);
    step(1);
    bus.ns_raw = 1'b0;
    step(4);
    check("ns_hold_red", 32'(bus.ns_count), 32'd1);

    // 3. departure after two green cycles; interrupted green restarts the timer
    bus.ns_light = green;
    step(1);
    check("ns_green1", 32'(bus.ns_count), 32'd1);
    step(1);
    check("ns_green2_count", 32'(bus.ns_count), 32'd0);
    check("ns_green2_sensor", 32'(bus.ns_sensor), 32'd0);
    bus.ns_light = red;
    arrive(2);
    check("ns_rearrive", 32'(bus.ns_count), 32'd1);
    bus.ns_light = green;
    step(1);
    bus.ns_light = red;
    step(1);
    bus.ns_light = green;
    step(1);
    check("ns_timer_cleared", 32'(bus.ns_count), 32'd1);
    step(1);
    check("ns_green_after_clear", 32'(bus.ns_count), 32'd0);
    bus.ns_light = red;

    // 4. arrival coinciding with departure leaves the queue unchanged
    for (int i = 0; i < 3; i++) arrive(1);
    check("left_q3", 32'(bus.ew_left_count), 32'd3);
    bus.ew_left_raw = 1'b1;
    step(2);
    bus.ew_left_light = green;
    step(1);
    check("left_pre_coincide", 32'(bus.ew_left_count), 32'd3);
    step(1);
    check("left_coincide", 32'(bus.ew_left_count), 32'd3);
    bus.ew_left_raw = 1'b0;
    step(1);
    check("left_after_1green", 32'(bus.ew_left_count), 32'd3);
    step(1);
    check("left_after_2green", 32'(bus.ew_left_count), 32'd2);
    bus.ew_left_light = red;
    step(2);

    // 5. saturation at QMAX on ew_str
    for (int i = 1; i <= 17; i++) begin
      arrive(0);
      exp_q = (i > 15) ? 15 : i;
      check($sformatf("sat_%0d", i), 32'(bus.ew_str_count), 32'(exp_q));
    end
    check("sat_sensor", 32'(bus.ew_str_sensor), 32'd1);

    // 6. stuck detector (forced sensor only when the feature is built in)
    bus.ns_raw = 1'b1;
    step(63);
    check("stuck_before", 32'(bus.stuck), 32'd0);
    step(1);
    check("stuck_at_64", 32'(bus.stuck), STUCK_EN ? 32'd4 : 32'd0);
    check("stuck_ns_count", 32'(bus.ns_count), 32'd1);
    bus.ns_raw   = 1'b0;
    bus.ns_light = green;
    step(2);
    check("stuck_drain_count", 32'(bus.ns_count), 32'd0);
    check("stuck_drain_sensor", 32'(bus.ns_sensor), STUCK_EN ? 32'd1 : 32'd0);
    check("stuck_sticky", 32'(bus.stuck), STUCK_EN ? 32'd4 : 32'd0);
    bus.ns_light = red;

    // Mid-operation reset discards the queue on the same edge
    reset = 1'b1;
    step(1);
    check("mid_rst_ew_str", 32'(bus.ew_str_count), 32'd0);
    check("mid_rst_ew_left", 32'(bus.ew_left_count), 32'd0);
    check("mid_rst_stuck", 32'(bus.stuck), 32'd0);
    check("mid_rst_sensors", 32'({bus.ns_sensor, bus.ew_left_sensor, bus.ew_str_sensor}), 32'd0);
    reset = 1'b0;
    step(2);
    check("post_rst_ew_str", 32'(bus.ew_str_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
